// File: rtl/nn_ctrl_pkg.sv
// Shared definitions for neural-network layer controllers: the state encoding
// and the width helper used to size the counters.
package nn_ctrl_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        BCAST = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    // A counter always needs at least one bit, even when $clog2 would return 0.
    function automatic int clog2w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/vec_buffer.sv
// Simple dual-port vector store: one write port and one registered read port.
module vec_buffer
    import nn_ctrl_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int WIDTH      = 16,
    parameter int ADDR_WIDTH = clog2w(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [WIDTH-1:0]      wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [WIDTH-1:0]      rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_addr] <= wr_data;
        if (rd_en)
            rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/layer_stream_ctrl.sv
// Fully-connected layer sequencer: collects a vector, broadcasts it to all neurons,
// gathers their outputs and drains them serially. Optional watchdog: LAYER_CTRL_TIMEOUT_EN.
module layer_stream_ctrl
    import nn_ctrl_pkg::*;
#(
    parameter int numInput  = 4,
    parameter int numNeuron = 3,
    parameter int dataWidth = 16,
    parameter int TIMEOUT   = 1024
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [dataWidth-1:0]           in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic [dataWidth-1:0]           nrn_data,
    output logic                           nrn_valid,
    input  logic [numNeuron-1:0]           nrn_outvalid,
    input  logic [numNeuron*dataWidth-1:0] nrn_out,
    output logic [dataWidth-1:0]           out_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic                           busy,
    output logic                           err_unexp,
    output logic                           timeout_err
);

    localparam int WW = clog2w(numInput);
    localparam int BW = clog2w(numInput + 1);
    localparam int RW = clog2w(numNeuron);
    localparam logic [WW-1:0]        WLAST = WW'(numInput - 1);
    localparam logic [BW-1:0]        BDONE = BW'(numInput);
    localparam logic [RW-1:0]        RLAST = RW'(numNeuron - 1);
    localparam logic [numNeuron-1:0] FULL  = '1;

    if (TIMEOUT < 1) begin : g_bad_timeout
        $error("layer_stream_ctrl: TIMEOUT must be at least 1");
    end

    state_t                 state, next_state;
    logic [WW-1:0]          wcnt;
    logic [BW-1:0]          bcnt;
    logic [RW-1:0]          rcnt;
    logic [numNeuron-1:0]   mask, mask_next;
    logic [dataWidth-1:0]   outreg [numNeuron];
    logic [dataWidth-1:0]   rd_data;
    logic                   nrn_valid_q, err_q;
    logic                   in_hs, out_hs, rd_en, all_in, timed_out;

    assign in_hs     = in_valid && in_ready;
    assign out_hs    = out_valid && out_ready;
    assign mask_next = mask | nrn_outvalid;
    assign all_in    = (mask_next == FULL);

`ifdef LAYER_CTRL_TIMEOUT_EN
    localparam int TW = clog2w(TIMEOUT);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] tcnt;
    logic          tout_q;

    assign timed_out = (state == WAIT) && !all_in && (tcnt == TLAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt   <= '0;
            tout_q <= 1'b0;
        end else if (state != WAIT) begin
            tcnt <= '0;
        end else begin
            if (timed_out)
                tout_q <= 1'b1;
            if (tcnt != TLAST)
                tcnt <= tcnt + TW'(1);
        end
    end

    assign timeout_err = tout_q;
`else
    assign timed_out   = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst)
            state <= LOAD;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            LOAD:    if (in_hs && wcnt == WLAST) next_state = BCAST;
            BCAST:   if (bcnt == BDONE) next_state = WAIT;
            WAIT:    if (all_in || timed_out) next_state = DRAIN;
            DRAIN:   if (out_hs && rcnt == RLAST) next_state = LOAD;
            default: next_state = LOAD;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        rd_en     = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            BCAST:   rd_en     = (bcnt != BDONE);
            DRAIN:   out_valid = 1'b1;
            default: begin end
        endcase
    end

    // The read issued in one BCAST cycle appears on nrn_data the next, so valid trails rd_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            wcnt        <= '0;
            bcnt        <= '0;
            rcnt        <= '0;
            mask        <= '0;
            nrn_valid_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            nrn_valid_q <= rd_en;
            if ((|nrn_outvalid) && state != WAIT)
                err_q <= 1'b1;
            if (in_hs)
                wcnt <= (wcnt == WLAST) ? '0 : wcnt + WW'(1);
            if (state != BCAST)
                bcnt <= '0;
            else if (bcnt != BDONE)
                bcnt <= bcnt + BW'(1);
            mask <= (state == WAIT && !(all_in || timed_out)) ? mask_next : '0;
            if (out_hs)
                rcnt <= (rcnt == RLAST) ? '0 : rcnt + RW'(1);
        end
    end

    // Cleared when entering WAIT so a neuron that never reports drains as zero.
    always_ff @(posedge clk) begin
        for (int k = 0; k < numNeuron; k++) begin
            if (state == BCAST && next_state == WAIT)
                outreg[k] <= '0;
            else if (state == WAIT && nrn_outvalid[k])
                outreg[k] <= nrn_out[k*dataWidth +: dataWidth];
        end
    end

    vec_buffer #(
        .DEPTH (numInput),
        .WIDTH (dataWidth)
    ) u_vec_buffer (
        .clk     (clk),
        .wr_en   (in_hs),
        .wr_addr (wcnt),
        .wr_data (in_data),
        .rd_en   (rd_en),
        .rd_addr (WW'(bcnt)),
        .rd_data (rd_data)
    );

    assign nrn_valid = nrn_valid_q;
    assign nrn_data  = nrn_valid_q ? rd_data : '0;
    assign out_data  = out_valid ? outreg[rcnt] : '0;
    assign err_unexp = err_q;

endmodule

// File: tb/tb_layer_stream_ctrl.sv
// Self-checking bench for layer_stream_ctrl: directed and randomized layer rounds
// compared against a transaction-level model of the layer's expected traffic.
module tb_layer_stream_ctrl;

    localparam int NI = 4;
    localparam int NN = 3;
    localparam int DW = 16;
    localparam int TO = 16;

    logic               clk = 1'b0;
    logic               rst;
    logic [DW-1:0]      in_data;
    logic               in_valid;
    logic               in_ready;
    logic [DW-1:0]      nrn_data;
    logic               nrn_valid;
    logic [NN-1:0]      nrn_outvalid;
    logic [NN*DW-1:0]   nrn_out;
    logic [DW-1:0]      out_data;
    logic               out_valid;
    logic               out_ready;
    logic               busy;
    logic               err_unexp;
    logic               timeout_err;

    layer_stream_ctrl #(
        .numInput  (NI),
        .numNeuron (NN),
        .dataWidth (DW),
        .TIMEOUT   (TO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .nrn_data     (nrn_data),
        .nrn_valid    (nrn_valid),
        .nrn_outvalid (nrn_outvalid),
        .nrn_out      (nrn_out),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .busy         (busy),
        .err_unexp    (err_unexp),
        .timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] vec   [NI];
    logic [DW-1:0] outs  [NN];
    int            delays[NN];
    int            readyPat[$];
    int            maxGap;
    logic          expErr;
    logic          expTout;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic randomizeRound();
        for (int i = 0; i < NI; i++) vec[i] = DW'($urandom);
        for (int k = 0; k < NN; k++) begin
            outs[k]   = DW'($urandom);
            delays[k] = $urandom_range(0, 5);
        end
        readyPat.delete();
        maxGap = $urandom_range(0, 2);
    endtask

    task automatic loadVector();
        for (int i = 0; i < NI; i++) begin
            repeat ($urandom_range(0, maxGap)) begin
                in_valid = 1'b0;
                in_data  = DW'($urandom);
                step();
            end
            checkOutput("in_ready_load", in_ready, 1);
            in_valid = 1'b1;
            in_data  = vec[i];
            step();
        end
        in_valid = 1'b0;
        in_data  = DW'($urandom);
    endtask

    // Burst must start two cycles after the last handshake and run without gaps.
    task automatic expectBurst();
        checkOutput("bcast_lead", nrn_valid, 0);
        checkOutput("busy_bcast", busy, 1);
        checkOutput("in_ready_bcast", in_ready, 0);
        step();
        for (int k = 0; k < NI; k++) begin
            checkOutput("burst_valid", nrn_valid, 1);
            checkOutput("burst_data", nrn_data, vec[k]);
            step();
        end
        checkOutput("burst_end", nrn_valid, 0);
    endtask

    task automatic reportNeurons();
        int  lastCycle;
        logic missing;
        missing   = 1'b0;
        lastCycle = 0;
        for (int k = 0; k < NN; k++) begin
            if (delays[k] < 0) missing = 1'b1;
            else if (delays[k] > lastCycle) lastCycle = delays[k];
        end
        if (missing) lastCycle = TO - 1;
        for (int j = 0; j <= lastCycle; j++) begin
            checkOutput("wait_hold", out_valid, 0);
            checkOutput("wait_tout", timeout_err, expTout);
            nrn_outvalid = '0;
            nrn_out      = {$urandom, $urandom};
            for (int k = 0; k < NN; k++) begin
                if (delays[k] == j) begin
                    nrn_outvalid[k]      = 1'b1;
                    nrn_out[k*DW +: DW]  = outs[k];
                end
            end
            step();
            nrn_outvalid = '0;
        end
        if (missing) expTout = 1'b1;
        checkOutput("drain_enter", out_valid, 1);
        checkOutput("drain_tout", timeout_err, expTout);
    endtask

    task automatic drainOutputs();
        int idx;
        int n;
        logic r;
        logic [DW-1:0] expOut;
        idx = 0;
        n   = 0;
        while (idx < NN && n < 64) begin
            if (readyPat.size() > 0) r = (n < readyPat.size()) ? readyPat[n][0] : 1'b1;
            else r = 1'(($urandom % 2));
            expOut = (delays[idx] < 0) ? '0 : outs[idx];
            checkOutput("drain_valid", out_valid, 1);
            checkOutput("drain_data", out_data, expOut);
            out_ready = r;
            step();
            if (r) idx++;
            n++;
        end
        out_ready = 1'b0;
        if (idx != NN) checkOutput("drain_beats", idx, NN);
        checkOutput("drain_done_valid", out_valid, 0);
        checkOutput("drain_done_data", out_data, 0);
        checkOutput("in_ready_after", in_ready, 1);
        checkOutput("busy_after", busy, 0);
    endtask

    task automatic applyStimulus();
        loadVector();
        expectBurst();
        reportNeurons();
        drainOutputs();
        checkOutput("err_unexp", err_unexp, expErr);
        checkOutput("timeout_err", timeout_err, expTout);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_in_ready"}, in_ready, 1);
        checkOutput({tag, "_nrn_valid"}, nrn_valid, 0);
        checkOutput({tag, "_out_valid"}, out_valid, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_nrn_data"}, nrn_data, 0);
        checkOutput({tag, "_out_data"}, out_data, 0);
        checkOutput({tag, "_err_unexp"}, err_unexp, 0);
        checkOutput({tag, "_timeout_err"}, timeout_err, 0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst          = 1'b1;
        in_data      = '0;
        in_valid     = 1'b0;
        nrn_outvalid = '0;
        nrn_out      = '0;
        out_ready    = 1'b0;
        expErr       = 1'b0;
        expTout      = 1'b0;
        step();
        step();
        checkIdle("reset");
        rst = 1'b0;

        $display("[TB] T1 back-to-back vector 1,2,3,4");
        randomizeRound();
        for (int i = 0; i < NI; i++) vec[i] = DW'(i + 1);
        maxGap = 0;
        applyStimulus();

        $display("[TB] T2 simultaneous outvalid, out_ready held high");
        randomizeRound();
        outs[0] = 16'h0100; outs[1] = 16'h0200; outs[2] = 16'h0300;
        delays[0] = 0; delays[1] = 0; delays[2] = 0;
        readyPat = '{1, 1, 1};
        applyStimulus();

        $display("[TB] T3 staggered outvalid");
        randomizeRound();
        delays[2] = 0; delays[0] = 3; delays[1] = 4;
        applyStimulus();

        $display("[TB] T4 out_ready stalls");
        randomizeRound();
        readyPat = '{1, 0, 0, 1, 1};
        applyStimulus();

        $display("[TB] T5 reset during broadcast");
        randomizeRound();
        loadVector();
        checkOutput("t5_lead", nrn_valid, 0);
        step();
        for (int k = 0; k < 2; k++) begin
            checkOutput("t5_burst_data", nrn_data, vec[k]);
            step();
        end
        checkOutput("t5_elem2", nrn_data, vec[2]);
        rst = 1'b1;
        step();
        rst = 1'b0;
        checkIdle("t5_abort");
        randomizeRound();
        applyStimulus();

        $display("[TB] random rounds");
        for (int r = 0; r < 6; r++) begin
            randomizeRound();
            applyStimulus();
        end

`ifdef LAYER_CTRL_TIMEOUT_EN
        $display("[TB] T6 watchdog with a silent neuron");
        randomizeRound();
        delays[0] = 0; delays[1] = -1; delays[2] = 5;
        applyStimulus();
        randomizeRound();
        applyStimulus();
`endif

        $display("[TB] T6 spurious outvalid in LOAD");
        nrn_outvalid = 3'b010;
        nrn_out      = {$urandom, $urandom};
        step();
        nrn_outvalid = '0;
        expErr = 1'b1;
        checkOutput("err_set", err_unexp, 1);
        checkOutput("err_in_ready", in_ready, 1);
        checkOutput("err_busy", busy, 0);
        randomizeRound();
        applyStimulus();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
